// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control path: state codes shown on the
// hex display and the default per-play timeout.
package jogo_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_INICIA_RODADA  = 4'h2,
    ST_ESPERA_JOGADA  = 4'h3,
    ST_REGISTRA       = 4'h4,
    ST_COMPARA        = 4'h5,
    ST_PROXIMA_JOGADA = 4'h6,
    ST_PROXIMA_RODADA = 4'h7,
    ST_FIM_ACERTO     = 4'hA,
    ST_FIM_TIMEOUT    = 4'hD,
    ST_FIM_ERRO       = 4'hE
  } estado_t;

  // End-of-game states are the only ones besides inicial that accept iniciar.
  function automatic logic eh_fim(input estado_t s);
    return (s == ST_FIM_ACERTO) || (s == ST_FIM_TIMEOUT) || (s == ST_FIM_ERRO);
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Control/status bundle between the round sequencer (master) and the
// memory-game datapath (slave).
interface unidade_controle_rodadas_if;

  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimR;
  logic       zeraE;
  logic       contaE;
  logic       zeraR;
  logic       contaR;
  logic       zeraReg;
  logic       registraReg;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fimE, fimR,
    output zeraE, contaE, zeraR, contaR, zeraReg, registraReg,
    output acertou, errou, timeout, pronto, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fimE, fimR,
    input  zeraE, contaE, zeraR, contaR, zeraReg, registraReg,
    input  acertou, errou, timeout, pronto, db_estado
  );

endinterface

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play wait timer: counts while enabled, clears on zera, flags the last
// cycle of the TIMEOUT_CYCLES window.
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (zera) begin
      count_d = '0;
    end else if (conta) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim = (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round-based Moore sequencer for the memory game. Define TIMEOUT_EN to include
// the per-play timer and the fim_timeout state; otherwise plays wait forever.
module unidade_controle_rodadas
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  unidade_controle_rodadas_if.master bus
);

  estado_t    state_q, state_d;
  logic       expira;

  logic       zera_e_q, zera_e_d;
  logic       conta_e_q, conta_e_d;
  logic       zera_r_q, zera_r_d;
  logic       conta_r_q, conta_r_d;
  logic       zera_reg_q, zera_reg_d;
  logic       registra_reg_q, registra_reg_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic       pronto_q, pronto_d;
  logic [3:0] db_estado_q, db_estado_d;

`ifdef TIMEOUT_EN
  logic timeout_q, timeout_d;

  // Timer runs only in espera_jogada so every play gets a fresh window.
  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != ST_ESPERA_JOGADA),
    .conta (state_q == ST_ESPERA_JOGADA),
    .fim   (expira)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expira = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INICIAL: begin
        if (bus.iniciar) state_d = ST_PREPARACAO;
      end
      ST_PREPARACAO:     state_d = ST_INICIA_RODADA;
      ST_INICIA_RODADA:  state_d = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        if (bus.jogada) begin
          state_d = ST_REGISTRA;
        end else if (expira) begin
          state_d = ST_FIM_TIMEOUT;
        end
      end
      ST_REGISTRA:       state_d = ST_COMPARA;
      ST_COMPARA: begin
        if (!bus.igual) begin
          state_d = ST_FIM_ERRO;
        end else if (!bus.fimE) begin
          state_d = ST_PROXIMA_JOGADA;
        end else if (!bus.fimR) begin
          state_d = ST_PROXIMA_RODADA;
        end else begin
          state_d = ST_FIM_ACERTO;
        end
      end
      ST_PROXIMA_JOGADA: state_d = ST_ESPERA_JOGADA;
      ST_PROXIMA_RODADA: state_d = ST_INICIA_RODADA;
      default: begin
        if (!eh_fim(state_q)) begin
          state_d = ST_INICIAL;
        end else if (bus.iniciar) begin
          state_d = ST_PREPARACAO;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track the
  // state register exactly while staying glitch-free.
  always_comb begin
    zera_e_d       = 1'b0;
    conta_e_d      = 1'b0;
    zera_r_d       = 1'b0;
    conta_r_d      = 1'b0;
    zera_reg_d     = 1'b0;
    registra_reg_d = 1'b0;
    acertou_d      = 1'b0;
    errou_d        = 1'b0;
    pronto_d       = 1'b0;
`ifdef TIMEOUT_EN
    timeout_d      = 1'b0;
`endif
    db_estado_d    = state_d;
    case (state_d)
      ST_PREPARACAO: begin
        zera_e_d   = 1'b1;
        zera_r_d   = 1'b1;
        zera_reg_d = 1'b1;
      end
      ST_INICIA_RODADA:  zera_e_d       = 1'b1;
      ST_REGISTRA:       registra_reg_d = 1'b1;
      ST_PROXIMA_JOGADA: conta_e_d      = 1'b1;
      ST_PROXIMA_RODADA: conta_r_d      = 1'b1;
      ST_FIM_ACERTO: begin
        pronto_d  = 1'b1;
        acertou_d = 1'b1;
      end
      ST_FIM_ERRO: begin
        pronto_d = 1'b1;
        errou_d  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto_d  = 1'b1;
        errou_d   = 1'b1;
`ifdef TIMEOUT_EN
        timeout_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_INICIAL;
      zera_e_q       <= 1'b0;
      conta_e_q      <= 1'b0;
      zera_r_q       <= 1'b0;
      conta_r_q      <= 1'b0;
      zera_reg_q     <= 1'b0;
      registra_reg_q <= 1'b0;
      acertou_q      <= 1'b0;
      errou_q        <= 1'b0;
      pronto_q       <= 1'b0;
`ifdef TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
      db_estado_q    <= 4'h0;
    end else begin
      state_q        <= state_d;
      zera_e_q       <= zera_e_d;
      conta_e_q      <= conta_e_d;
      zera_r_q       <= zera_r_d;
      conta_r_q      <= conta_r_d;
      zera_reg_q     <= zera_reg_d;
      registra_reg_q <= registra_reg_d;
      acertou_q      <= acertou_d;
      errou_q        <= errou_d;
      pronto_q       <= pronto_d;
`ifdef TIMEOUT_EN
      timeout_q      <= timeout_d;
`endif
      db_estado_q    <= db_estado_d;
    end
  end

  assign bus.zeraE       = zera_e_q;
  assign bus.contaE      = conta_e_q;
  assign bus.zeraR       = zera_r_q;
  assign bus.contaR      = conta_r_q;
  assign bus.zeraReg     = zera_reg_q;
  assign bus.registraReg = registra_reg_q;
  assign bus.acertou     = acertou_q;
  assign bus.errou       = errou_q;
  assign bus.pronto      = pronto_q;
  assign bus.db_estado   = db_estado_q;
`ifdef TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for the round sequencer: vector table for the main flow plus
// hand-written reset, full-game, timeout and mid-game-reset sequences.
module tb_unidade_controle_rodadas;

  // Output vector order: zeraE contaE zeraR contaR zeraReg registraReg acertou errou timeout pronto
  localparam logic [9:0] NONE = 10'b0000000000;
  localparam logic [9:0] PREP = 10'b1010100000;
  localparam logic [9:0] INIR = 10'b1000000000;
  localparam logic [9:0] REG  = 10'b0000010000;
  localparam logic [9:0] CE   = 10'b0100000000;
  localparam logic [9:0] CR   = 10'b0001000000;
  localparam logic [9:0] ACE  = 10'b0000001001;
  localparam logic [9:0] ERR  = 10'b0000000101;
  localparam logic [9:0] TMO  = 10'b0000000111;

  typedef struct {
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim_e;
    logic       fim_r;
    logic [3:0] estado;
    logic [9:0] saidas;
  } vec_t;

  logic clock;
  logic reset;
  int   n_compared;
  int   n_mismatch;
  int   conta_r_seen;

  unidade_controle_rodadas_if bus ();

  unidade_controle_rodadas #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] saidas_now();
    return {bus.zeraE, bus.contaE, bus.zeraR, bus.contaR, bus.zeraReg,
            bus.registraReg, bus.acertou, bus.errou, bus.timeout, bus.pronto};
  endfunction

  function automatic vec_t mk(input logic ini, input logic jog, input logic igu,
                              input logic fe, input logic fr,
                              input logic [3:0] est, input logic [9:0] sai);
    vec_t v;
    v.iniciar = ini;
    v.jogada  = jog;
    v.igual   = igu;
    v.fim_e   = fe;
    v.fim_r   = fr;
    v.estado  = est;
    v.saidas  = sai;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.contaR) conta_r_seen++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bus.iniciar = v.iniciar;
    bus.jogada  = v.jogada;
    bus.igual   = v.igual;
    bus.fimE    = v.fim_e;
    bus.fimR    = v.fim_r;
    tick();
    checkOutput($sformatf("vec%0d_estado", idx), 32'(bus.db_estado), 32'(v.estado));
    checkOutput($sformatf("vec%0d_saidas", idx), 32'(saidas_now()), 32'(v.saidas));
  endtask

  task automatic clear_inputs();
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.fimE    = 1'b0;
    bus.fimR    = 1'b0;
  endtask

  // Four rounds, every play correct; also measures per-play and per-round latency.
  task automatic play_perfect_game();
    int lat;
    conta_r_seen = 0;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    tick();
    checkOutput("game_wait_first", 32'(bus.db_estado), 32'h3);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p <= r; p++) begin
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        lat = 1;
        tick();
        lat++;
        bus.igual = 1'b1;
        bus.fimE  = (p == r);
        bus.fimR  = (r == 3);
        tick();
        lat++;
        bus.igual = 1'b0;
        bus.fimE  = 1'b0;
        bus.fimR  = 1'b0;
        if (!(p == r && r == 3)) begin
          while (bus.db_estado != 4'h3 && lat < 12) begin
            tick();
            lat++;
          end
          checkOutput($sformatf("latency_r%0d_p%0d", r, p), 32'(lat),
                      (p == r) ? 32'd5 : 32'd4);
        end
      end
    end
    checkOutput("game_estado", 32'(bus.db_estado), 32'hA);
    checkOutput("game_saidas", 32'(saidas_now()), 32'(ACE));
    checkOutput("game_contaR_pulses", 32'(conta_r_seen), 32'd3);
  endtask

  initial begin
    vec_t tbl[$];
    int   departures;

    n_compared   = 0;
    n_mismatch   = 0;
    conta_r_seen = 0;
    clear_inputs();

    // Reset held low with iniciar high: nothing may move.
    reset = 1'b0;
    bus.iniciar = 1'b1;
    tick();
    checkOutput("reset1_estado", 32'(bus.db_estado), 32'h0);
    checkOutput("reset1_saidas", 32'(saidas_now()), 32'(NONE));
    tick();
    checkOutput("reset2_estado", 32'(bus.db_estado), 32'h0);
    checkOutput("reset2_saidas", 32'(saidas_now()), 32'(NONE));
    reset = 1'b1;
    tick();
    checkOutput("release_estado", 32'(bus.db_estado), 32'h1);
    checkOutput("release_saidas", 32'(saidas_now()), 32'(PREP));
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;

    // Main flow: short game with a round advance, a miss, a restart and a win.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, PREP));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, INIR));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, NONE));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, NONE));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, REG));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, NONE));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, CR));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, INIR));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, NONE));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, REG));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, NONE));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, CE));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, NONE));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, REG));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, NONE));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hE, ERR));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, ERR));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, PREP));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, INIR));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, NONE));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, REG));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, NONE));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, ACE));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, ACE));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, PREP));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], i);
    end
    clear_inputs();

    play_perfect_game();

    // Restart from fim_acerto and sit in espera_jogada with no play.
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    checkOutput("restart_zeraR", 32'(bus.zeraR), 32'd1);
    tick();
    tick();
    checkOutput("wait_entered", 32'(bus.db_estado), 32'h3);
`ifdef TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    checkOutput("timeout_not_yet", 32'(bus.db_estado), 32'h3);
    tick();
    checkOutput("timeout_estado", 32'(bus.db_estado), 32'hD);
    checkOutput("timeout_saidas", 32'(saidas_now()), 32'(TMO));
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    tick();
    checkOutput("wait_again", 32'(bus.db_estado), 32'h3);
    for (int i = 0; i < 7; i++) tick();
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    checkOutput("jogada_wins_expiry", 32'(bus.db_estado), 32'h4);
`else
    departures = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.db_estado != 4'h3 || bus.timeout != 1'b0) departures++;
    end
    checkOutput("idle_departures", 32'(departures), 32'd0);
    checkOutput("idle_timeout", 32'(bus.timeout), 32'd0);
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    checkOutput("late_jogada", 32'(bus.db_estado), 32'h4);
`endif

    // Mid-game reset while in proxima_jogada.
    tick();
    bus.igual = 1'b1;
    tick();
    bus.igual = 1'b0;
    checkOutput("mid_estado6", 32'(bus.db_estado), 32'h6);
    checkOutput("mid_contaE", 32'(bus.contaE), 32'd1);
    reset = 1'b0;
    tick();
    checkOutput("midreset_estado", 32'(bus.db_estado), 32'h0);
    checkOutput("midreset_saidas", 32'(saidas_now()), 32'(NONE));
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", 32'(bus.db_estado), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
